// File: rtl/i2c_pkg.sv
// Shared types for the passive I2C bus monitor: event encoding, event record
// and the frame-tracking FSM state.
package i2c_pkg;

  typedef enum logic [1:0] {
    EVT_START  = 2'd0,
    EVT_RSTART = 2'd1,
    EVT_STOP   = 2'd2,
    EVT_BYTE   = 2'd3
  } i2c_evt_e;

  typedef struct packed {
    i2c_evt_e    typ;
    logic [7:0]  data;
    logic        ack;
    logic        err;
  } i2c_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } i2c_state_e;

  localparam int         BIT_CNT_W = 4;
  localparam logic [3:0] LAST_DATA_BIT = 4'd7;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser + stability filter + edge pulses for one open-drain bus line.
// The filtered line only moves after FILT_LEN consecutive equal synchronised
// samples, so pad-to-filtered latency is SYNC_STAGES + FILT_LEN cycles.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_filt,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   r_prev;
  logic                   w_in;
  logic                   w_samp;

  // A released (z) or unknown wire reads as the pulled-up level.
  assign w_in   = (i_line === 1'b0) ? 1'b0 : 1'b1;
  assign w_samp = r_sync[SYNC_STAGES-1];

  // Synchronise, then accept a new level only once it has been stable long enough.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
      r_prev <= r_filt;
      if (w_samp == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= w_samp;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_filt & ~r_prev;
  assign o_fall = ~r_filt & r_prev;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters sda/scl, detects START/RSTART/STOP,
// deserialises 9-bit frames and reports each as an event.
//
// Event handshake: evt_valid is high while the event register holds an
// unconsumed event; the event and its fields stay stable until the cycle in
// which evt_valid && evt_ready, where it is consumed. A new event arriving in
// that same cycle replaces it (valid stays 1); a new event arriving while
// evt_valid && !evt_ready is dropped and sets the sticky overflow flag.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       sda,
  input  logic       scl,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_type,
  output logic [7:0] evt_data,
  output logic       evt_ack,
  output logic       evt_err,
  output logic       bus_busy,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic [1:0] dbg_state
);

  logic w_sda_filt, w_sda_rise, w_sda_fall;
  logic w_scl_filt, w_scl_rise, w_scl_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk (system_clock),
    .i_rst (reset),
    .i_line(sda),
    .o_filt(w_sda_filt),
    .o_rise(w_sda_rise),
    .o_fall(w_sda_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk (system_clock),
    .i_rst (reset),
    .i_line(scl),
    .o_filt(w_scl_filt),
    .o_rise(w_scl_rise),
    .o_fall(w_scl_fall)
  );

  // START/STOP only while SCL is steadily high; an SDA edge coincident with an
  // SCL edge is treated as a data transition.
  logic w_cond_ok, w_start, w_stop;
  assign w_cond_ok = w_scl_filt & ~w_scl_rise & ~w_scl_fall;
  assign w_start   = w_cond_ok & w_sda_fall;
  assign w_stop    = w_cond_ok & w_sda_rise;

  i2c_state_e           r_state, w_state_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]           r_shreg, w_shreg_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_evt_new;
  i2c_evt_t             w_evt;
  logic                 w_frame_err;

  // Every STOP and repeated START is preceded by an SCL rise that the shifter
  // samples as a provisional bit, so a frame only counts as partial once more
  // than that one bit has been collected.
  assign w_frame_err = (r_bit_cnt > 4'd1);

  // Frame-tracking state, shift register, bit counter and busy flag.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state and event generation from bus conditions and SCL rises.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_busy_nxt    = r_busy;
    w_evt_new     = 1'b0;
    w_evt         = '0;
    if (w_start) begin
      w_evt_new     = 1'b1;
      w_evt.typ     = r_busy ? EVT_RSTART : EVT_START;
      w_evt.err     = w_frame_err;
      w_state_nxt   = ST_SHIFT;
      w_bit_cnt_nxt = '0;
      w_busy_nxt    = 1'b1;
    end else if (w_stop) begin
      w_evt_new     = 1'b1;
      w_evt.typ     = EVT_STOP;
      w_evt.err     = w_frame_err;
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = '0;
      w_busy_nxt    = 1'b0;
    end else if (w_scl_rise) begin
      case (r_state)
        ST_SHIFT: begin
          w_shreg_nxt   = {r_shreg[6:0], w_sda_filt};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == LAST_DATA_BIT) w_state_nxt = ST_ACK;
        end
        ST_ACK: begin
          w_evt_new     = 1'b1;
          w_evt.typ     = EVT_BYTE;
          w_evt.data    = r_shreg;
          w_evt.ack     = w_sda_filt;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_SHIFT;
        end
        default: ;
      endcase
    end
  end

  i2c_evt_t r_evt;
  logic     r_valid;
  logic     r_overflow;
  logic     w_drop;

  assign w_drop = w_evt_new & r_valid & ~evt_ready;

  // Event register with valid/ready handshake.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_evt   <= '0;
      r_valid <= 1'b0;
    end else if (w_evt_new && (!r_valid || evt_ready)) begin
      r_evt   <= w_evt;
      r_valid <= 1'b1;
    end else if (r_valid && evt_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign evt_valid = r_valid;
  assign evt_type  = r_evt.typ;
  assign evt_data  = r_evt.data;
  assign evt_ack   = r_evt.ack;
  assign evt_err   = r_evt.err;
  assign bus_busy  = r_busy;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bit-banged I2C sequences, expected
// events queued as stimulus is driven and compared as the DUT hands them over.
module tb_i2c_bus_monitor;
  import i2c_pkg::*;

  localparam int H = 8;  // system clocks per SCL half-phase step

  logic       system_clock;
  logic       reset;
  logic       sda;
  logic       scl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [7:0] evt_data;
  logic       evt_ack;
  logic       evt_err;
  logic       bus_busy;
  logic       overflow;
  logic       overflow_clr;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  i2c_bus_monitor #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .system_clock(system_clock),
    .reset       (reset),
    .sda         (sda),
    .scl         (scl),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_type    (evt_type),
    .evt_data    (evt_data),
    .evt_ack     (evt_ack),
    .evt_err     (evt_err),
    .bus_busy    (bus_busy),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic i2c_start();
    sda = 1'b1; scl = 1'b1; tick(H);
    sda = 1'b0; tick(H);
    scl = 1'b0; tick(H);
  endtask

  task automatic i2c_rstart();
    sda = 1'b1; tick(H);
    scl = 1'b1; tick(H);
    sda = 1'b0; tick(H);
    scl = 1'b0; tick(H);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; tick(H);
    scl = 1'b1; tick(H);
    sda = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    tick(H);
    scl = 1'b1; tick(H);
    scl = 1'b0; tick(H);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(ack);
  endtask

  function automatic void exp_evt(input i2c_evt_e t, input logic [7:0] d,
                                  input logic a, input logic e);
    exp_q.push_back({t, d, a, e});
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every handed-over event against the queue head
  always @(negedge system_clock) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_event: observed %0h expected none",
               {evt_type, evt_data, evt_ack, evt_err});
      end else begin
        logic [10:0] exp_v;
        logic [10:0] got_v;
        exp_v = exp_q.pop_front();
        got_v = {evt_type, evt_data, evt_ack, evt_err};
        checks++;
        assert (got_v === exp_v) else begin
          errors++;
          $error("FAIL event: observed type=%0d data=%02h ack=%0b err=%0b expected type=%0d data=%02h ack=%0b err=%0b",
                 got_v[10:9], got_v[8:1], got_v[0+1-1+1], got_v[0],
                 exp_v[10:9], exp_v[8:1], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; sda = 1'b1; scl = 1'b1; evt_ready = 1'b1; overflow_clr = 1'b0;
    tick(3);
    check("reset_outputs", {evt_valid, evt_type, evt_data, evt_ack, evt_err, bus_busy, overflow}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick(10);

    // 1: START, 0xA5 + ACK, STOP
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    check("t1_busy_after_start", bus_busy, 1);
    exp_evt(EVT_BYTE, 8'hA5, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0);
    exp_evt(EVT_STOP, 8'h00, 1'b0, 1'b0);
    i2c_stop();
    tick(H);
    check("t1_busy_after_stop", bus_busy, 0);

    // 2: START, 0x3C + NACK, RSTART, 0xC3 + ACK, STOP
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    exp_evt(EVT_BYTE, 8'h3C, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1);
    exp_evt(EVT_RSTART, 8'h00, 1'b0, 1'b0);
    i2c_rstart();
    check("t2_busy_after_rstart", bus_busy, 1);
    exp_evt(EVT_BYTE, 8'hC3, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0);
    exp_evt(EVT_STOP, 8'h00, 1'b0, 1'b0);
    i2c_stop();
    tick(H);

    // 3: one-cycle SDA glitch while SCL high is filtered out
    sda = 1'b0; tick(1);
    sda = 1'b1; tick(20);
    check("t3_no_event", evt_valid, 0);
    check("t3_busy", bus_busy, 0);

    // 4: STOP after 4 data bits flags the aborted frame, then a clean frame
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    exp_evt(EVT_STOP, 8'h00, 1'b0, 1'b1);
    i2c_stop();
    tick(H);
    check("t4_busy_after_abort", bus_busy, 0);
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    exp_evt(EVT_BYTE, 8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0);
    exp_evt(EVT_STOP, 8'h00, 1'b0, 1'b0);
    i2c_stop();
    tick(H);

    // 5: consumer stalled: START held, later events dropped, overflow sticky
    evt_ready = 1'b0;
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    send_byte(8'h77, 1'b0);
    check("t5_held_valid", evt_valid, 1);
    check("t5_held_type", evt_type, EVT_START);
    check("t5_overflow_set", overflow, 1);
    i2c_stop();
    tick(H);
    check("t5_busy_after_stop", bus_busy, 0);
    evt_ready = 1'b1;
    tick(2);
    check("t5_drained", evt_valid, 0);
    check("t5_overflow_sticky", overflow, 1);
    overflow_clr = 1'b1; tick(1);
    overflow_clr = 1'b0; tick(1);
    check("t5_overflow_cleared", overflow, 0);

    // 6: reset at bit_cnt=5, then the next START is a plain START
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t6_busy_before_reset", bus_busy, 1);
    reset = 1'b1; tick(1);
    check("t6_reset_outputs", {evt_valid, evt_type, evt_data, evt_ack, evt_err, bus_busy, overflow}, 0);
    check("t6_reset_state", dbg_state, ST_IDLE);
    tick(1);
    reset = 1'b0; scl = 1'b1; sda = 1'b1;
    tick(20);
    check("t6_no_event_after_reset", evt_valid, 0);
    exp_evt(EVT_START, 8'h00, 1'b0, 1'b0);
    i2c_start();
    exp_evt(EVT_BYTE, 8'h96, 1'b0, 1'b0);
    send_byte(8'h96, 1'b0);
    exp_evt(EVT_STOP, 8'h00, 1'b0, 1'b0);
    i2c_stop();

    // drain remaining expectations within a bounded window
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
